// File: rtl/data_access_unit.sv
// -----------------------------------------------------------------------------
// data_access_unit
//
// Purpose:
//    Sequences byte, halfword and word loads/stores against a 64-word data
//    memory with a one-cycle read latency. Sub-word stores are performed as a
//    read-modify-write. Misaligned or reserved-size requests are rejected
//    without touching memory. Byte lanes are big-endian.
//
// Ports:
//    clock_i          single clock, all state changes on posedge
//    reset_i          asynchronous active-high reset
//    start_i          request strobe, sampled only in IDLE
//    isStore_i        1 = store, 0 = load
//    size_i           00 byte, 01 halfword, 10 word, 11 reserved
//    unsigned_i       zero-extend sub-word loads when 1
//    byteAddress_i    byte address into the 256-byte data space
//    storeData_i      store operand (low-order bits used for sub-word)
//    memReadData_i    memory read data, valid the cycle after a read strobe
//    loadData_o       load result, held until the next completed load
//    busy_o           high in every state except IDLE
//    done_o           one-cycle completion pulse
//    alignError_o     pulses with done_o for a rejected request
//    memAddress_o     word address to the memory (0 when idle)
//    memWriteData_o   word to write
//    memoryRead_o     memory read strobe
//    memoryWrite_o    memory write strobe
// -----------------------------------------------------------------------------
module data_access_unit (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic        isStore_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [7:0]  byteAddress_i,
    input  logic [31:0] storeData_i,
    input  logic [31:0] memReadData_i,
    output logic [31:0] loadData_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        alignError_o,
    output logic [5:0]  memAddress_o,
    output logic [31:0] memWriteData_o,
    output logic        memoryRead_o,
    output logic        memoryWrite_o
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD     = 3'd1,
        RDWAIT = 3'd2,
        WR     = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t      state_q;
    logic [7:0]  addr_q;
    logic [15:0] storeData_q;
    logic [1:0]  size_q;
    logic        isStore_q;
    logic        unsigned_q;
    logic        alignErr_q;
    logic [31:0] loadData_q;
    logic [31:0] memWriteData_q;

    logic        misaligned_d;
    logic [31:0] loadResult_d;
    logic [31:0] mergedWord_d;
    logic [7:0]  byteSel;
    logic [15:0] halfSel;

    // Alignment check on the live request inputs, used only when Start is
    // accepted in IDLE. The reserved size is treated as always misaligned.
    always_comb begin
        misaligned_d = 1'b0;
        case (size_i)
            2'b00:   misaligned_d = 1'b0;
            2'b01:   misaligned_d = byteAddress_i[0];
            2'b10:   misaligned_d = |byteAddress_i[1:0];
            default: misaligned_d = 1'b1;
        endcase
    end

    // Lane extraction and extension for loads. Offset 0 is the most
    // significant byte of the word.
    always_comb begin
        byteSel      = 8'h00;
        halfSel      = 16'h0000;
        loadResult_d = memReadData_i;
        case (addr_q[1:0])
            2'b00:   byteSel = memReadData_i[31:24];
            2'b01:   byteSel = memReadData_i[23:16];
            2'b10:   byteSel = memReadData_i[15:8];
            default: byteSel = memReadData_i[7:0];
        endcase
        halfSel = addr_q[1] ? memReadData_i[15:0] : memReadData_i[31:16];
        case (size_q)
            2'b00:   loadResult_d = unsigned_q ? {24'h000000, byteSel}
                                               : {{24{byteSel[7]}}, byteSel};
            2'b01:   loadResult_d = unsigned_q ? {16'h0000, halfSel}
                                               : {{16{halfSel[15]}}, halfSel};
            default: loadResult_d = memReadData_i;
        endcase
    end

    // Read-modify-write merge: the addressed lane takes the store operand,
    // every other lane keeps what was just read from memory.
    always_comb begin
        mergedWord_d = memReadData_i;
        if (size_q == 2'b00) begin
            case (addr_q[1:0])
                2'b00:   mergedWord_d[31:24] = storeData_q[7:0];
                2'b01:   mergedWord_d[23:16] = storeData_q[7:0];
                2'b10:   mergedWord_d[15:8]  = storeData_q[7:0];
                default: mergedWord_d[7:0]   = storeData_q[7:0];
            endcase
        end else begin
            if (addr_q[1]) begin
                mergedWord_d[15:0] = storeData_q;
            end else begin
                mergedWord_d[31:16] = storeData_q;
            end
        end
    end

    // Main sequencer. A word store skips the read phase and loads its write
    // data straight from the operand on entry; misaligned requests jump to
    // DONE so no strobe is ever raised for them.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q        <= IDLE;
            addr_q         <= 8'h00;
            storeData_q    <= 16'h0000;
            size_q         <= 2'b00;
            isStore_q      <= 1'b0;
            unsigned_q     <= 1'b0;
            alignErr_q     <= 1'b0;
            loadData_q     <= 32'h0;
            memWriteData_q <= 32'h0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        addr_q      <= byteAddress_i;
                        storeData_q <= storeData_i[15:0];
                        size_q      <= size_i;
                        isStore_q   <= isStore_i;
                        unsigned_q  <= unsigned_i;
                        alignErr_q  <= misaligned_d;
                        if (misaligned_d) begin
                            state_q <= DONE;
                        end else if (isStore_i && (size_i == 2'b10)) begin
                            memWriteData_q <= storeData_i;
                            state_q        <= WR;
                        end else begin
                            state_q <= RD;
                        end
                    end
                end
                RD: begin
                    state_q <= RDWAIT;
                end
                RDWAIT: begin
                    if (isStore_q) begin
                        memWriteData_q <= mergedWord_d;
                        state_q        <= WR;
                    end else begin
                        loadData_q <= loadResult_d;
                        state_q    <= DONE;
                    end
                end
                WR: begin
                    state_q <= DONE;
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Control outputs are pure decodes of the state register so that no
    // request input can reach a strobe combinationally.
    assign busy_o         = (state_q != IDLE);
    assign done_o         = (state_q == DONE);
    assign alignError_o   = (state_q == DONE) && alignErr_q;
    assign memoryRead_o   = (state_q == RD);
    assign memoryWrite_o  = (state_q == WR);
    assign memAddress_o   = (state_q != IDLE) ? addr_q[7:2] : 6'd0;
    assign loadData_o     = loadData_q;
    assign memWriteData_o = memWriteData_q;

endmodule

// File: tb/tb_data_access_unit.sv
// -----------------------------------------------------------------------------
// tb_data_access_unit
//
// Purpose:
//    Self-checking bench for data_access_unit. Drives directed and random
//    requests, models the data memory, and compares against a reference model
//    that computes loads, stores, latencies and strobe counts arithmetically.
// -----------------------------------------------------------------------------
module tb_data_access_unit;

    logic        clock;
    logic        reset;
    logic        start;
    logic        isStore;
    logic [1:0]  size;
    logic        unsignedLoad;
    logic [7:0]  byteAddress;
    logic [31:0] storeData;
    logic [31:0] memReadData;
    logic [31:0] loadData;
    logic        busy;
    logic        done;
    logic        alignError;
    logic [5:0]  memAddress;
    logic [31:0] memWriteData;
    logic        memoryRead;
    logic        memoryWrite;

    int compared;
    int mismatched;

    logic [31:0] tbMem  [64];
    logic [31:0] refMem [64];
    logic [31:0] lastLoad;

    data_access_unit dut (
        .clock_i        (clock),
        .reset_i        (reset),
        .start_i        (start),
        .isStore_i      (isStore),
        .size_i         (size),
        .unsigned_i     (unsignedLoad),
        .byteAddress_i  (byteAddress),
        .storeData_i    (storeData),
        .memReadData_i  (memReadData),
        .loadData_o     (loadData),
        .busy_o         (busy),
        .done_o         (done),
        .alignError_o   (alignError),
        .memAddress_o   (memAddress),
        .memWriteData_o (memWriteData),
        .memoryRead_o   (memoryRead),
        .memoryWrite_o  (memoryWrite)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Data memory: one-cycle read latency, write on the strobed edge.
    always @(posedge clock) begin
        if (memoryWrite) begin
            tbMem[memAddress] <= memWriteData;
        end
        if (memoryRead) begin
            memReadData <= tbMem[memAddress];
        end
    end

    // Hard stop in case something hangs outside the bounded waits.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Reference load: extract a big-endian lane and extend it.
    function automatic logic [31:0] refLoad(input logic [31:0] word, input int offset,
                                            input int sz, input bit uns);
        logic [31:0] v;
        if (sz == 0) begin
            v = (word >> (8 * (3 - offset))) & 32'hFF;
            if (!uns && v >= 32'h80) v = v | 32'hFFFFFF00;
        end else if (sz == 1) begin
            v = (word >> (16 * (1 - offset / 2))) & 32'hFFFF;
            if (!uns && v >= 32'h8000) v = v | 32'hFFFF0000;
        end else begin
            v = word;
        end
        return v;
    endfunction

    // Reference store: replace the addressed lane of the old word.
    function automatic logic [31:0] refStore(input logic [31:0] word, input int offset,
                                             input int sz, input logic [31:0] sd);
        logic [31:0] mask;
        int          shift;
        if (sz == 0) begin
            shift = 8 * (3 - offset);
            mask  = 32'hFF << shift;
            return (word & ~mask) | ((sd & 32'hFF) << shift);
        end else if (sz == 1) begin
            shift = 16 * (1 - offset / 2);
            mask  = 32'hFFFF << shift;
            return (word & ~mask) | ((sd & 32'hFFFF) << shift);
        end
        return sd;
    endfunction

    // Issues one request, follows it to Done and checks everything the model
    // predicts. Returns at the negedge of the IDLE cycle after Done, so the
    // next call can present a back-to-back Start.
    task automatic applyStimulus(input bit st, input logic [1:0] sz, input bit uns,
                                 input logic [7:0] a, input logic [31:0] sd,
                                 input bit holdStart);
        int  cycles;
        int  reads;
        int  writes;
        int  expLat;
        int  expReads;
        int  expWrites;
        int  off;
        bit  mis;
        bit  sawDone;

        off = int'(a) % 4;
        mis = (sz == 2'd3) || (sz == 2'd1 && (off % 2) != 0) || (sz == 2'd2 && off != 0);
        if (mis) begin
            expLat = 1; expReads = 0; expWrites = 0;
        end else if (!st) begin
            expLat = 3; expReads = 1; expWrites = 0;
        end else if (sz == 2'd2) begin
            expLat = 2; expReads = 0; expWrites = 1;
        end else begin
            expLat = 4; expReads = 1; expWrites = 1;
        end

        start        = 1'b1;
        isStore      = st;
        size         = sz;
        unsignedLoad = uns;
        byteAddress  = a;
        storeData    = sd;
        @(posedge clock);
        #1;
        if (!holdStart) start = 1'b0;
        isStore      = $urandom_range(0, 1);
        size         = 2'($urandom_range(0, 3));
        unsignedLoad = $urandom_range(0, 1);
        byteAddress  = 8'($urandom);
        storeData    = $urandom;

        cycles  = 0;
        reads   = 0;
        writes  = 0;
        sawDone = 1'b0;
        while (!sawDone && cycles < 20) begin
            @(negedge clock);
            cycles++;
            if (memoryRead)  reads++;
            if (memoryWrite) writes++;
            if (cycles == 1) checkOutput("mem_address", 32'(memAddress), 32'(a >> 2));
            if (done) sawDone = 1'b1;
        end
        start = 1'b0;
        if (!sawDone) begin
            checkOutput("done_timeout", 32'(sawDone), 32'd1);
            return;
        end

        if (!mis) begin
            if (st) refMem[a >> 2] = refStore(refMem[a >> 2], off, int'(sz), sd);
            else    lastLoad       = refLoad(refMem[a >> 2], off, int'(sz), uns);
        end

        checkOutput("latency",     32'(cycles),     32'(expLat));
        checkOutput("align_error", 32'(alignError), 32'(mis));
        checkOutput("load_data",   loadData,        lastLoad);
        checkOutput("read_count",  32'(reads),      32'(expReads));
        checkOutput("write_count", 32'(writes),     32'(expWrites));
        @(negedge clock);
        checkOutput("mem_word",    tbMem[a >> 2],   refMem[a >> 2]);
        checkOutput("idle_busy",   32'(busy),       32'd0);
        checkOutput("idle_done",   32'(done),       32'd0);
    endtask

    // Starts a halfword store at 0x0E and hits reset in the given cycle
    // (2 = RDWAIT, 3 = WR). Checks outputs clear at once and that the
    // abandoned write never lands.
    task automatic resetMidOp(input int atCycle);
        int strayWrites;
        start       = 1'b1;
        isStore     = 1'b1;
        size        = 2'b01;
        byteAddress = 8'h0E;
        storeData   = 32'h0000BEEF;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (atCycle) @(negedge clock);
        if (atCycle == 3) checkOutput("wr_before_reset", 32'(memoryWrite), 32'd1);
        reset = 1'b1;
        #1;
        checkOutput("rst_busy",       32'(busy),        32'd0);
        checkOutput("rst_done",       32'(done),        32'd0);
        checkOutput("rst_align",      32'(alignError),  32'd0);
        checkOutput("rst_read",       32'(memoryRead),  32'd0);
        checkOutput("rst_write",      32'(memoryWrite), 32'd0);
        checkOutput("rst_load_data",  loadData,         32'h0);
        checkOutput("rst_write_data", memWriteData,     32'h0);
        checkOutput("rst_mem_addr",   32'(memAddress),  32'd0);
        lastLoad = 32'h0;
        @(negedge clock);
        reset = 1'b0;
        strayWrites = 0;
        repeat (4) begin
            @(negedge clock);
            if (memoryWrite || busy) strayWrites++;
        end
        checkOutput("no_resume", 32'(strayWrites), 32'd0);
        checkOutput("word3_kept", tbMem[3], refMem[3]);
    endtask

    initial begin
        compared     = 0;
        mismatched   = 0;
        lastLoad     = 32'h0;
        reset        = 1'b1;
        start        = 1'b0;
        isStore      = 1'b0;
        size         = 2'b00;
        unsignedLoad = 1'b0;
        byteAddress  = 8'h00;
        storeData    = 32'h0;
        for (int i = 0; i < 64; i++) begin
            tbMem[i]  = $urandom;
            refMem[i] = tbMem[i];
        end
        tbMem[3]  = 32'h80FF7F01;
        refMem[3] = 32'h80FF7F01;

        repeat (2) @(negedge clock);
        checkOutput("reset_busy",       32'(busy),        32'd0);
        checkOutput("reset_done",       32'(done),        32'd0);
        checkOutput("reset_strobes",    32'({memoryRead, memoryWrite}), 32'd0);
        checkOutput("reset_load_data",  loadData,         32'h0);
        checkOutput("reset_write_data", memWriteData,     32'h0);
        checkOutput("reset_mem_addr",   32'(memAddress),  32'd0);
        reset = 1'b0;

        // Loads from word 3 with known results.
        applyStimulus(1'b0, 2'b00, 1'b0, 8'h0C, 32'h0, 1'b0);
        checkOutput("lb_0c",  loadData, 32'hFFFFFF80);
        applyStimulus(1'b0, 2'b00, 1'b1, 8'h0C, 32'h0, 1'b0);
        checkOutput("lbu_0c", loadData, 32'h00000080);
        applyStimulus(1'b0, 2'b01, 1'b0, 8'h0E, 32'h0, 1'b0);
        checkOutput("lh_0e",  loadData, 32'h00007F01);
        applyStimulus(1'b0, 2'b01, 1'b1, 8'h0C, 32'h0, 1'b0);
        checkOutput("lhu_0c", loadData, 32'h000080FF);

        // Misaligned and reserved-size requests leave LoadData alone.
        applyStimulus(1'b0, 2'b01, 1'b0, 8'h0D, 32'h0, 1'b0);
        checkOutput("lh_0d_hold", loadData, 32'h000080FF);
        applyStimulus(1'b1, 2'b11, 1'b0, 8'h10, 32'h12345678, 1'b0);
        applyStimulus(1'b0, 2'b10, 1'b0, 8'h0E, 32'h0, 1'b0);

        // Reset abandons a sub-word store in RDWAIT and in WR.
        resetMidOp(2);
        resetMidOp(3);
        applyStimulus(1'b0, 2'b10, 1'b0, 8'h0C, 32'h0, 1'b0);
        checkOutput("lw_0c_after_reset", loadData, 32'h80FF7F01);

        // Byte store and word store with known results.
        applyStimulus(1'b1, 2'b00, 1'b0, 8'h0D, 32'h123456AB, 1'b0);
        checkOutput("sb_0d_word3", tbMem[3], 32'h80AB7F01);
        applyStimulus(1'b1, 2'b10, 1'b0, 8'h10, 32'hDEADBEEF, 1'b0);
        checkOutput("sw_10_word4", tbMem[4], 32'hDEADBEEF);

        // Start held high through a load: exactly one access.
        applyStimulus(1'b0, 2'b10, 1'b0, 8'h10, 32'h0, 1'b1);
        checkOutput("lw_held_start", loadData, 32'hDEADBEEF);

        // Random traffic, mostly back-to-back.
        for (int n = 0; n < 200; n++) begin
            applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)), 8'($urandom), $urandom,
                          ($urandom_range(0, 3) == 0));
        end

        for (int i = 0; i < 64; i++) begin
            checkOutput($sformatf("final_mem[%0d]", i), tbMem[i], refMem[i]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
